// File: rtl/div_unit_pkg.sv
// Shared types and constants for the iterative divider.
// Holds the FSM state encoding and the default iteration count.
package div_unit_pkg;

  localparam int DIV_CYCLES_DEF = 32;
  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } divState_t;

  // Two's-complement magnitude when the operand is treated as signed.
  function automatic logic [XLEN-1:0] magOf(
    input logic [XLEN-1:0] v,
    input logic            isSigned
  );
    return (isSigned && v[XLEN-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// Ports: remIn/divisor/quoIn in, remOut/quoOut out.
import div_unit_pkg::*;

module div_step (
  input  logic [XLEN:0]   remIn,
  input  logic [XLEN-1:0] divisor,
  input  logic [XLEN-1:0] quoIn,
  output logic [XLEN:0]   remOut,
  output logic [XLEN-1:0] quoOut
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          noBorrow;

  // Next dividend bit comes out of the top of the quotient shifter.
  assign shifted = {remIn[XLEN-1:0], quoIn[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor};

  // A set top bit means the shifted value overflowed past the
  // divisor's range, so the subtraction always succeeds.
  assign noBorrow = remIn[XLEN] | ~diff[XLEN];

  assign remOut = noBorrow ? diff : shifted;
  assign quoOut = {quoIn[XLEN-2:0], noBorrow};

endmodule

// File: rtl/div_unit.sv
// Multi-cycle div/divu unit for the EX stage, one quotient bit per cycle.
// Ports: clk, rst, startE, signedE, srcaE, srcbE, cancel in;
//        divstallE, readyE, hi (remainder), lo (quotient) out.
import div_unit_pkg::*;

module div_unit #(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            startE,
  input  logic            signedE,
  input  logic [XLEN-1:0] srcaE,
  input  logic [XLEN-1:0] srcbE,
  input  logic            cancel,
  output logic            divstallE,
  output logic            readyE,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW =
    (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

  divState_t       state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] divisorQ;
  logic [XLEN:0]   remQ;
  logic [XLEN-1:0] quoQ;
  logic            qNeg;
  logic            rNeg;
  logic            divZero;

  logic [XLEN:0]   stepRem;
  logic [XLEN-1:0] stepQuo;
  logic            accept;

  div_step u_step (
    .remIn   (remQ),
    .divisor (divisorQ),
    .quoIn   (quoQ),
    .remOut  (stepRem),
    .quoOut  (stepQuo)
  );

  assign accept = (state == IDLE) & startE & ~cancel;

  // Gated by rst so a pending startE cannot stall the pipe
  // while the unit is held in reset.
  assign divstallE = ~rst & (accept | (state == BUSY));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      divisorQ <= '0;
      remQ     <= '0;
      quoQ     <= '0;
      qNeg     <= 1'b0;
      rNeg     <= 1'b0;
      divZero  <= 1'b0;
      readyE   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      readyE <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        count <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            if (startE) begin
              // Dividend magnitude seeds the quotient shifter.
              quoQ     <= magOf(srcaE, signedE);
              divisorQ <= magOf(srcbE, signedE);
              remQ     <= '0;
              qNeg     <= signedE & (srcaE[XLEN-1] ^ srcbE[XLEN-1]);
              rNeg     <= signedE & srcaE[XLEN-1];
              divZero  <= (srcbE == '0);
              count    <= '0;
              state    <= BUSY;
            end
          end
          BUSY: begin
            remQ  <= stepRem;
            quoQ  <= stepQuo;
            count <= count + 1'b1;
            if (count == LAST) begin
              // Result lands as DONE is entered so hi/lo and
              // readyE are all visible during the DONE cycle.
              // Remainder of x/0 is |x|, and the sign fix
              // restores the raw dividend, so only lo needs
              // the zero-divisor override.
              state  <= DONE;
              count  <= '0;
              readyE <= 1'b1;
              hi     <= rNeg ? -stepRem[XLEN-1:0]
                             : stepRem[XLEN-1:0];
              lo     <= divZero ? '1
                      : (qNeg ? -stepQuo : stepQuo);
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
// Each task drives one scenario and checks its own results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        startE = 1'b0;
  logic        signedE = 1'b0;
  logic [31:0] srcaE = '0;
  logic [31:0] srcbE = '0;
  logic        cancel = 1'b0;
  logic        divstallE;
  logic        readyE;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  div_unit dut (
    .clk       (clk),
    .rst       (rst),
    .startE    (startE),
    .signedE   (signedE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .cancel    (cancel),
    .divstallE (divstallE),
    .readyE    (readyE),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic issue(input logic s, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    startE  = 1'b1;
    signedE = s;
    srcaE   = a;
    srcbE   = b;
  endtask

  // Counts cycles from the start cycle until readyE, bounded.
  task automatic waitReady(input bit hold, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!hold) startE = 1'b0;
    end while (!readyE && n < 40);
  endtask

  task automatic test_reset;
    startE = 1'b1;
    srcaE  = 32'd10;
    srcbE  = 32'd2;
    #1;
    tests++;
    if (divstallE !== 1'b0) begin
      fails++;
      $display("FAIL reset_stall got %b want 0", divstallE);
    end
    tests++;
    if (hi !== 0 || lo !== 0 || readyE !== 1'b0) begin
      fails++;
      $display("FAIL reset_regs got hi=%h lo=%h rdy=%b want 0 0 0",
               hi, lo, readyE);
    end
    startE = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_divu_basic;
    int bad;
    issue(1'b0, 32'd100, 32'd7);
    #1;
    tests++;
    if (divstallE !== 1'b1) begin
      fails++;
      $display("FAIL divu_stall_T got %b want 1", divstallE);
    end
    bad = 0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      startE = 1'b0;
      #1;
      if (divstallE !== 1'b1 || readyE !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL divu_busy got %0d bad cycles want 0", bad);
    end
    @(negedge clk);
    tests++;
    if (readyE !== 1'b1 || divstallE !== 1'b0) begin
      fails++;
      $display("FAIL divu_done got rdy=%b stall=%b want 1 0",
               readyE, divstallE);
    end
    tests++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      fails++;
      $display("FAIL divu_100_7 got lo=%0d hi=%0d want 14 2", lo, hi);
    end
    @(negedge clk);
    tests++;
    if (readyE !== 1'b0) begin
      fails++;
      $display("FAIL divu_pulse got rdy=%b want 0", readyE);
    end
  endtask

  task automatic test_signed;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] eq [4];
    logic [31:0] er [4];
    int n;
    va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;
    eq[0] = 32'hFFFFFFFD; er[0] = 32'hFFFFFFFF;
    va[1] = 32'd7;        vb[1] = 32'hFFFFFFFE;
    eq[1] = 32'hFFFFFFFD; er[1] = 32'd1;
    va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF;
    eq[2] = 32'h80000000; er[2] = 32'd0;
    va[3] = 32'hFFFFFFFB; vb[3] = 32'd0;
    eq[3] = 32'hFFFFFFFF; er[3] = 32'hFFFFFFFB;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, va[i], vb[i]);
      waitReady(1'b0, n);
      tests++;
      if (n !== 33) begin
        fails++;
        $display("FAIL div_lat[%0d] got %0d want 33", i, n);
      end
      tests++;
      if (lo !== eq[i] || hi !== er[i]) begin
        fails++;
        $display("FAIL div[%0d] got lo=%h hi=%h want %h %h",
                 i, lo, hi, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_divzero_u;
    int n;
    issue(1'b0, 32'd5, 32'd0);
    waitReady(1'b0, n);
    tests++;
    if (n !== 33 || lo !== 32'hFFFFFFFF || hi !== 32'd5) begin
      fails++;
      $display("FAIL divu_5_0 got n=%0d lo=%h hi=%h want 33 ffffffff 5",
               n, lo, hi);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    issue(1'b0, 32'd50, 32'd7);
    waitReady(1'b1, n);
    tests++;
    if (n !== 33 || lo !== 32'd7 || hi !== 32'd1) begin
      fails++;
      $display("FAIL b2b_first got n=%0d lo=%0d hi=%0d want 33 7 1",
               n, lo, hi);
    end
    srcaE = 32'd20;
    srcbE = 32'd3;
    @(negedge clk);
    #1;
    tests++;
    if (readyE !== 1'b0 || divstallE !== 1'b1) begin
      fails++;
      $display("FAIL b2b_idle got rdy=%b stall=%b want 0 1",
               readyE, divstallE);
    end
    waitReady(1'b0, n);
    tests++;
    if (n !== 33 || lo !== 32'd6 || hi !== 32'd2) begin
      fails++;
      $display("FAIL b2b_second got n=%0d lo=%0d hi=%0d want 33 6 2",
               n, lo, hi);
    end
  endtask

  task automatic test_cancel;
    int seen;
    issue(1'b0, 32'd1000, 32'd3);
    repeat (11) begin
      @(negedge clk);
      startE = 1'b0;
    end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    #1;
    tests++;
    if (divstallE !== 1'b0 || readyE !== 1'b0) begin
      fails++;
      $display("FAIL cancel_idle got stall=%b rdy=%b want 0 0",
               divstallE, readyE);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (readyE !== 1'b0 || divstallE !== 1'b0) seen++;
    end
    tests++;
    if (seen != 0 || lo !== 32'd6 || hi !== 32'd2) begin
      fails++;
      $display("FAIL cancel_hold got bad=%0d lo=%0d hi=%0d want 0 6 2",
               seen, lo, hi);
    end
  endtask

  task automatic test_async_reset;
    int n;
    issue(1'b0, 32'd1000, 32'd3);
    repeat (21) begin
      @(negedge clk);
      startE = 1'b0;
    end
    #2;
    rst = 1'b1;
    #1;
    tests++;
    if (hi !== 0 || lo !== 0 || divstallE !== 1'b0
        || readyE !== 1'b0) begin
      fails++;
      $display("FAIL async_rst got hi=%h lo=%h stall=%b want 0 0 0",
               hi, lo, divstallE);
    end
    #1;
    rst     = 1'b0;
    startE  = 1'b1;
    signedE = 1'b0;
    srcaE   = 32'd9;
    srcbE   = 32'd3;
    waitReady(1'b0, n);
    tests++;
    if (n !== 33 || lo !== 32'd3 || hi !== 32'd0) begin
      fails++;
      $display("FAIL rst_then_9_3 got n=%0d lo=%0d hi=%0d want 33 3 0",
               n, lo, hi);
    end
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_divzero_u();
    test_back_to_back();
    test_cancel();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
